// File: rtl/elevator_pkg.sv
// Shared types and constants for the SCAN elevator controller:
// FSM state encoding, the half-step coil table and a width helper.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } elev_state_t;

    // Half-step coil patterns {A,B,C,D}, indexed by phase 0..7 (entry 0 is the rightmost).
    localparam logic [7:0][3:0] HALF_STEP_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    // Bits needed to hold any value 0..max_val, never less than one.
    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/elevator_scan_ctrl_stepper_phase_gen.sv
// Half-step generator for a 4-wire unipolar stepper.
// While run is high the divider issues one step_tick every STEP_DIV cycles;
// each tick moves the phase one position up or down. motorpin is a registered
// copy of the table entry for the current phase, so it trails the phase by one cycle.
// coil_off forces the coils dark without disturbing the stored phase.
module stepper_phase_gen
    import elevator_pkg::*;
#(
    parameter int STEP_DIV = 75000
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       run,
    input  logic       dir_up,
    input  logic       coil_off,
    output logic       step_tick,
    output logic [3:0] motorpin
);

    localparam int DW = count_width(STEP_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [2:0]    phase;

    assign step_tick = run && (div_cnt == DIV_LAST);

    // Step divider: counts 0..STEP_DIV-1 while running, parked at 0 otherwise.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            div_cnt <= '0;
        end else if (!run || step_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Phase register: one half-step per tick, wrapping mod 8 in either direction.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            phase <= 3'd0;
        end else if (step_tick) begin
            phase <= dir_up ? phase + 3'd1 : phase - 3'd1;
        end
    end

    // Coil drive register: table lookup of the phase, or all-off when gated.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            motorpin <= 4'b0000;
        end else begin
            motorpin <= coil_off ? 4'b0000 : HALF_STEP_TABLE[phase];
        end
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor elevator controller with SCAN scheduling driving a half-step stepper.
// Calls are latched into a pending mask; the car keeps its direction while calls
// remain ahead, otherwise reverses. Position is tracked as floor + steps into the
// current floor span. The door dwells DOOR_DWELL cycles at each served floor.
// Optional build macro: ELEV_IDLE_COIL_OFF_EN -- when defined, the coils are
// de-energised whenever the car is in IDLE or DOOR; otherwise they hold the last pattern.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS      = 4,
    parameter int STEPS_PER_FLOOR = 11719,
    parameter int STEP_DIV        = 75000,
    parameter int DOOR_DWELL      = 100000000
) (
    input  logic                                    clk,
    input  logic                                    reset_p,
    input  logic [NUM_FLOORS-1:0]                   call_req,
    output logic [3:0]                              motorpin,
    output logic [count_width(NUM_FLOORS-1)-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0]                   pending,
    output logic                                    moving,
    output logic                                    dir_up,
    output logic                                    door_open,
    output elev_state_t                             fsm_state
);

    localparam int FW  = count_width(NUM_FLOORS - 1);
    localparam int CW  = count_width(STEPS_PER_FLOOR);
    localparam int DWW = count_width(DOOR_DWELL);

    localparam logic [CW-1:0]  CNT_LAST   = CW'(STEPS_PER_FLOOR - 1);
    localparam logic [DWW-1:0] DWELL_LAST = DWW'(DOOR_DWELL - 1);
    localparam logic [FW-1:0]  TOP_FLOOR  = FW'(NUM_FLOORS - 1);

    elev_state_t           state, next_state;
    logic                  dir_q, dir_next;
    logic [CW-1:0]         floor_cnt;
    logic [DWW-1:0]        dwell_cnt;
    logic [NUM_FLOORS-1:0] pending_next;
    logic [NUM_FLOORS-1:0] above_mask, below_mask;
    logic                  calls_above, calls_below;
    logic [FW-1:0]         next_floor;
    logic [FW-1:0]         door_floor;
    logic                  door_entry;
    logic                  boundary;
    logic                  arrive_stop;
    logic                  step_tick;
    logic                  coil_off;

    stepper_phase_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_phase_gen (
        .clk       (clk),
        .reset_p   (reset_p),
        .run       (state == MOVE),
        .dir_up    (dir_q),
        .coil_off  (coil_off),
        .step_tick (step_tick),
        .motorpin  (motorpin)
    );

`ifdef ELEV_IDLE_COIL_OFF_EN
    // Gate on the upcoming state so the coils go dark on the same edge the car stops.
    assign coil_off = (next_state != MOVE);
`else
    assign coil_off = 1'b0;
`endif

    // Which floors lie above / below the car, for the SCAN direction decision.
    always_comb begin
        above_mask = '0;
        below_mask = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            above_mask[f] = (f > int'(cur_floor));
            below_mask[f] = (f < int'(cur_floor));
        end
    end

    assign calls_above = |(pending & above_mask);
    assign calls_below = |(pending & below_mask);
    assign next_floor  = dir_q ? cur_floor + FW'(1) : cur_floor - FW'(1);
    assign boundary    = step_tick && (floor_cnt == CNT_LAST);
    // End floors always stop the car, even if the call mask were somehow empty there.
    assign arrive_stop = boundary &&
                         (pending[next_floor] || next_floor == '0 || next_floor == TOP_FLOOR);

    // Next-state and direction logic for the SCAN FSM.
    always_comb begin
        next_state = state;
        dir_next   = dir_q;
        door_entry = 1'b0;
        door_floor = cur_floor;
        case (state)
            IDLE: begin
                if (pending[cur_floor]) begin
                    next_state = DOOR;
                    door_entry = 1'b1;
                end else if (dir_q ? calls_above : calls_below) begin
                    next_state = MOVE;
                end else if (dir_q ? calls_below : calls_above) begin
                    next_state = MOVE;
                    dir_next   = !dir_q;
                end
            end
            MOVE: begin
                if (arrive_stop) begin
                    next_state = DOOR;
                    door_entry = 1'b1;
                    door_floor = next_floor;
                end
            end
            DOOR: begin
                if (dwell_cnt == DWELL_LAST && !call_req[cur_floor]) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Pending mask update: latch new calls, drop the floor being served,
    // and swallow calls for the floor whose door is (or is about to be) open.
    always_comb begin
        pending_next = pending | call_req;
        if (state == DOOR) begin
            pending_next[cur_floor] = 1'b0;
        end
        if (door_entry) begin
            pending_next[door_floor] = 1'b0;
        end
    end

    // FSM, direction and pending registers.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state   <= IDLE;
            dir_q   <= 1'b1;
            pending <= '0;
        end else begin
            state   <= next_state;
            dir_q   <= dir_next;
            pending <= pending_next;
        end
    end

    // Position tracking: steps into the current span, and the last floor reached.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            floor_cnt <= '0;
            cur_floor <= '0;
        end else if (boundary) begin
            floor_cnt <= '0;
            cur_floor <= next_floor;
        end else if (step_tick) begin
            floor_cnt <= floor_cnt + CW'(1);
        end
    end

    // Door dwell timer: runs in DOOR, restarted by a call for the open floor.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            dwell_cnt <= '0;
        end else if (state != DOOR || call_req[cur_floor]) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + DWW'(1);
        end
    end

    assign moving    = (state == MOVE);
    assign door_open = (state == DOOR);
    assign dir_up    = dir_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed testbench for elevator_scan_ctrl with small timing parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_elevator_scan_ctrl;

    localparam int NF  = 4;
    localparam int SPF = 8;
    localparam int SD  = 4;
    localparam int DD  = 10;

`ifdef ELEV_IDLE_COIL_OFF_EN
    localparam bit COIL_OFF = 1'b1;
`else
    localparam bit COIL_OFF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_p;
    logic [NF-1:0] call_req;
    logic [3:0]    motorpin;
    logic [1:0]    cur_floor;
    logic [NF-1:0] pending;
    logic          moving;
    logic          dir_up;
    logic          door_open;
    logic [1:0]    fsm_state;

    int checks   = 0;
    int failures = 0;

    // Clock generation.
    always #5 clk = ~clk;

    elevator_scan_ctrl #(
        .NUM_FLOORS      (NF),
        .STEPS_PER_FLOOR (SPF),
        .STEP_DIV        (SD),
        .DOOR_DWELL      (DD)
    ) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .call_req  (call_req),
        .motorpin  (motorpin),
        .cur_floor (cur_floor),
        .pending   (pending),
        .moving    (moving),
        .dir_up    (dir_up),
        .door_open (door_open),
        .fsm_state (fsm_state)
    );

    // Expected coil pattern for a half-step phase.
    function automatic logic [3:0] coil(input int p);
        case (p & 7)
            0: return 4'b1000;
            1: return 4'b1100;
            2: return 4'b0100;
            3: return 4'b0110;
            4: return 4'b0010;
            5: return 4'b0011;
            6: return 4'b0001;
            default: return 4'b1001;
        endcase
    endfunction

    // Pattern expected while parked at phase p.
    function automatic logic [3:0] parked(input int p);
        return COIL_OFF ? 4'b0000 : coil(p);
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a one-cycle call pulse starting at the current falling edge.
    task automatic pulse_call(input logic [NF-1:0] v);
        call_req = v;
        wait_cycles(1);
        call_req = '0;
    endtask

    task automatic test_reset();
        reset_p  = 1'b1;
        call_req = '0;
        wait_cycles(2);
        checks++; if (motorpin !== 4'b0000) begin failures++; $display("FAIL rst_motorpin: got %b want %b", motorpin, 4'b0000); end
        checks++; if (cur_floor !== 2'd0) begin failures++; $display("FAIL rst_floor: got %0d want 0", cur_floor); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL rst_pending: got %b want 0000", pending); end
        checks++; if (moving !== 1'b0) begin failures++; $display("FAIL rst_moving: got %b want 0", moving); end
        checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL rst_door: got %b want 0", door_open); end
        checks++; if (dir_up !== 1'b1) begin failures++; $display("FAIL rst_dir: got %b want 1", dir_up); end
        reset_p = 1'b0;
        wait_cycles(1);
        checks++; if (motorpin !== parked(0)) begin failures++; $display("FAIL rst_release_motorpin: got %b want %b", motorpin, parked(0)); end
    endtask

    // Call for the floor the car is already parked at: door opens, no steps.
    task automatic test_idle_door();
        call_req = 4'b0001;
        wait_cycles(1);
        call_req = '0;
        checks++; if (pending !== 4'b0001) begin failures++; $display("FAIL idle_pending_latch: got %b want 0001", pending); end
        checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL idle_door_early: got %b want 0", door_open); end
        wait_cycles(1);
        checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL idle_door_open: got %b want 1", door_open); end
        checks++; if (moving !== 1'b0) begin failures++; $display("FAIL idle_moving: got %b want 0", moving); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL idle_pending_clr: got %b want 0000", pending); end
        checks++; if (motorpin !== parked(0)) begin failures++; $display("FAIL idle_motorpin: got %b want %b", motorpin, parked(0)); end
        wait_cycles(9);
        checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL idle_door_last: got %b want 1", door_open); end
        wait_cycles(1);
        checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL idle_door_close: got %b want 0", door_open); end
        checks++; if (cur_floor !== 2'd0) begin failures++; $display("FAIL idle_floor: got %0d want 0", cur_floor); end
    endtask

    // Floor 0 -> 2: sixteen up-steps, phase sequence, floor counts, door dwell.
    task automatic test_scan_up();
        logic [3:0] exp_pin;
        pulse_call(4'b0100);
        checks++; if (pending !== 4'b0100) begin failures++; $display("FAIL up_pending: got %b want 0100", pending); end
        checks++; if (moving !== 1'b0) begin failures++; $display("FAIL up_moving_early: got %b want 0", moving); end
        wait_cycles(1);
        checks++; if (moving !== 1'b1) begin failures++; $display("FAIL up_moving_start: got %b want 1", moving); end
        checks++; if (dir_up !== 1'b1) begin failures++; $display("FAIL up_dir: got %b want 1", dir_up); end
        for (int k = 1; k <= 16; k++) begin
            wait_cycles(SD);
            exp_pin = (k == 16 && COIL_OFF) ? 4'b0000 : coil(k - 1);
            checks++; if (motorpin !== exp_pin) begin failures++; $display("FAIL up_step%0d_motorpin: got %b want %b", k, motorpin, exp_pin); end
            checks++; if (cur_floor !== 2'(k / SPF)) begin failures++; $display("FAIL up_step%0d_floor: got %0d want %0d", k, cur_floor, k / SPF); end
            checks++; if (moving !== (k < 16)) begin failures++; $display("FAIL up_step%0d_moving: got %b want %b", k, moving, (k < 16)); end
        end
        checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL up_door_open: got %b want 1", door_open); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL up_pending_clr: got %b want 0000", pending); end
        for (int i = 1; i <= 9; i++) begin
            wait_cycles(1);
            checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL up_dwell%0d: got %b want 1", i, door_open); end
            checks++; if (motorpin !== parked(0)) begin failures++; $display("FAIL up_dwell%0d_motorpin: got %b want %b", i, motorpin, parked(0)); end
        end
        wait_cycles(1);
        checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL up_door_close: got %b want 0", door_open); end
        checks++; if (moving !== 1'b0) begin failures++; $display("FAIL up_idle: got %b want 0", moving); end
    endtask

    // 0 -> 3 with a call for 1 arriving behind the car, then reverse to 1.
    task automatic test_scan_reverse();
        pulse_call(4'b1000);
        wait_cycles(1);
        checks++; if (moving !== 1'b1) begin failures++; $display("FAIL rev_moving_start: got %b want 1", moving); end
        wait_cycles(40);
        pulse_call(4'b0010);
        checks++; if (pending !== 4'b1010) begin failures++; $display("FAIL rev_pending_mid: got %b want 1010", pending); end
        wait_cycles(23);
        checks++; if (cur_floor !== 2'd2) begin failures++; $display("FAIL rev_pass2_floor: got %0d want 2", cur_floor); end
        checks++; if (moving !== 1'b1) begin failures++; $display("FAIL rev_pass2_moving: got %b want 1", moving); end
        checks++; if (pending !== 4'b1010) begin failures++; $display("FAIL rev_pass2_pending: got %b want 1010", pending); end
        wait_cycles(32);
        checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL rev_top_door: got %b want 1", door_open); end
        checks++; if (cur_floor !== 2'd3) begin failures++; $display("FAIL rev_top_floor: got %0d want 3", cur_floor); end
        checks++; if (pending !== 4'b0010) begin failures++; $display("FAIL rev_top_pending: got %b want 0010", pending); end
        wait_cycles(11);
        checks++; if (moving !== 1'b1) begin failures++; $display("FAIL rev_down_moving: got %b want 1", moving); end
        checks++; if (dir_up !== 1'b0) begin failures++; $display("FAIL rev_down_dir: got %b want 0", dir_up); end
        wait_cycles(5);
        checks++; if (motorpin !== coil(7)) begin failures++; $display("FAIL rev_down_phase: got %b want %b", motorpin, coil(7)); end
        wait_cycles(27);
        checks++; if (cur_floor !== 2'd2) begin failures++; $display("FAIL rev_down_pass2: got %0d want 2", cur_floor); end
        checks++; if (moving !== 1'b1) begin failures++; $display("FAIL rev_down_pass2_moving: got %b want 1", moving); end
        wait_cycles(32);
        checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL rev_floor1_door: got %b want 1", door_open); end
        checks++; if (cur_floor !== 2'd1) begin failures++; $display("FAIL rev_floor1: got %0d want 1", cur_floor); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL rev_floor1_pending: got %b want 0000", pending); end
        wait_cycles(10);
        checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL rev_floor1_close: got %b want 0", door_open); end
    endtask

    // Call on the arrival cycle is absorbed; call during DOOR restarts the dwell.
    task automatic test_back_to_back();
        pulse_call(4'b0100);
        wait_cycles(1);
        checks++; if (dir_up !== 1'b1) begin failures++; $display("FAIL b2b_dir_flip: got %b want 1", dir_up); end
        wait_cycles(31);
        call_req = 4'b0100;
        wait_cycles(1);
        call_req = '0;
        checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL b2b_arrive_door: got %b want 1", door_open); end
        checks++; if (cur_floor !== 2'd2) begin failures++; $display("FAIL b2b_arrive_floor: got %0d want 2", cur_floor); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL b2b_absorb: got %b want 0000", pending); end
        wait_cycles(3);
        pulse_call(4'b0100);
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL b2b_door_call_latched: got %b want 0000", pending); end
        wait_cycles(9);
        checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL b2b_dwell_restart: got %b want 1", door_open); end
        wait_cycles(1);
        checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL b2b_dwell_end: got %b want 0", door_open); end
        wait_cycles(1);
        checks++; if (moving !== 1'b0) begin failures++; $display("FAIL b2b_no_second_stop: got %b want 0", moving); end
    endtask

    // Asynchronous reset while moving, then a one-floor trip of exactly SPF steps.
    task automatic test_reset_mid_move();
        pulse_call(4'b0001);
        wait_cycles(11);
        checks++; if (moving !== 1'b1) begin failures++; $display("FAIL mid_moving_before: got %b want 1", moving); end
        #2;
        reset_p = 1'b1;
        #1;
        checks++; if (moving !== 1'b0) begin failures++; $display("FAIL mid_async_moving: got %b want 0", moving); end
        checks++; if (cur_floor !== 2'd0) begin failures++; $display("FAIL mid_async_floor: got %0d want 0", cur_floor); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL mid_async_pending: got %b want 0000", pending); end
        checks++; if (motorpin !== 4'b0000) begin failures++; $display("FAIL mid_async_motorpin: got %b want 0000", motorpin); end
        checks++; if (dir_up !== 1'b1) begin failures++; $display("FAIL mid_async_dir: got %b want 1", dir_up); end
        checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL mid_async_door: got %b want 0", door_open); end
        wait_cycles(2);
        reset_p = 1'b0;
        wait_cycles(1);
        pulse_call(4'b0010);
        wait_cycles(1);
        checks++; if (moving !== 1'b1) begin failures++; $display("FAIL mid_trip_start: got %b want 1", moving); end
        wait_cycles(31);
        checks++; if (cur_floor !== 2'd0) begin failures++; $display("FAIL mid_trip_step7_floor: got %0d want 0", cur_floor); end
        checks++; if (moving !== 1'b1) begin failures++; $display("FAIL mid_trip_step7_moving: got %b want 1", moving); end
        wait_cycles(1);
        checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL mid_trip_step8_door: got %b want 1", door_open); end
        checks++; if (cur_floor !== 2'd1) begin failures++; $display("FAIL mid_trip_step8_floor: got %0d want 1", cur_floor); end
        wait_cycles(1);
        checks++; if (motorpin !== parked(0)) begin failures++; $display("FAIL mid_trip_door_motorpin: got %b want %b", motorpin, parked(0)); end
        wait_cycles(10);
    endtask

    initial begin
        reset_p  = 1'b1;
        call_req = '0;
        test_reset();
        test_idle_door();
        test_scan_up();
        test_reset();
        test_scan_reverse();
        test_back_to_back();
        test_reset_mid_move();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
